fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer that shares one single-port RAM
// between instruction fetch and a load/store data port. It feeds an external
// instruction FIFO with {pc, instruction} packets and follows taken branches
// on the returning fetch data, so a branch costs no extra cycle.
module fetch_ctrl #(
  parameter int I_WIDTH    = 13,
  parameter int A_WIDTH    = 10,
  parameter int O_WIDTH    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       restart_i,
  input  logic [A_WIDTH-1:0]         restart_addr_i,
  input  logic                       dequeue_i,
  input  logic                       load_store_valid_i,
  input  logic                       store_en_i,
  input  logic [A_WIDTH-1:0]         load_store_addr_i,
  input  logic [I_WIDTH-1:0]         store_data_i,
  input  logic [I_WIDTH-1:0]         ram_data_i,
  output logic [A_WIDTH-1:0]         ram_addr_o,
  output logic                       ram_we_o,
  output logic [I_WIDTH-1:0]         ram_wdata_o,
  output logic                       load_store_ready_o,
  output logic [I_WIDTH-1:0]         load_data_o,
  output logic                       load_data_valid_o,
  output logic                       fifo_enqueue_o,
  output logic                       fifo_clear_o,
  output logic [A_WIDTH+I_WIDTH-1:0] instr_packet_o
);

  // Counter must be able to hold the value FIFO_DEPTH itself.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]        DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]      ONE_C   = CW'(1);
  localparam logic [A_WIDTH-1:0] ONE_A   = A_WIDTH'(1);

  logic [A_WIDTH-1:0] pc_q, pc_d;
  logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic               fetch_inflight_q, fetch_inflight_d;
  logic               load_inflight_q, load_inflight_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               is_branch;
  logic [A_WIDTH-1:0] offset_ext;
  logic [A_WIDTH-1:0] branch_target;
  logic [A_WIDTH-1:0] next_pc;
  logic               room;
  logic               enqueue;
  logic               deq_ok;

  // A returning fetch whose MSB is set is a relative branch off its own pc.
  assign is_branch     = fetch_inflight_q & ram_data_i[I_WIDTH-1];
  assign offset_ext    = {{(A_WIDTH-O_WIDTH){ram_data_i[O_WIDTH-1]}}, ram_data_i[O_WIDTH-1:0]};
  assign branch_target = fetch_pc_q + offset_ext;
  assign next_pc       = is_branch ? branch_target : pc_q;

  // Fetches in flight are counted as occupied so the FIFO can never overflow.
  assign room    = ({1'b0, cnt_q} + {{CW{1'b0}}, fetch_inflight_q}) < DEPTH_C;
  // A fetch returning during a restart (or reset) is dropped.
  assign enqueue = reset_n & fetch_inflight_q & ~restart_i;
  assign deq_ok  = dequeue_i & (cnt_q != '0);

  assign ram_wdata_o       = store_data_i;
  assign load_data_o       = ram_data_i;
  assign load_data_valid_o = load_inflight_q;
  assign fifo_enqueue_o    = enqueue;
  assign fifo_clear_o      = restart_i | ~reset_n;
  assign instr_packet_o    = {fetch_pc_q, ram_data_i};

  // RAM port arbitration: restart fetch > load/store > normal fetch.
  always_comb begin
    pc_d               = pc_q;
    fetch_pc_d         = fetch_pc_q;
    fetch_inflight_d   = 1'b0;
    load_inflight_d    = 1'b0;
    ram_addr_o         = next_pc;
    ram_we_o           = 1'b0;
    load_store_ready_o = 1'b0;
    if (restart_i) begin
      ram_addr_o       = restart_addr_i;
      fetch_pc_d       = restart_addr_i;
      fetch_inflight_d = 1'b1;
      pc_d             = restart_addr_i + ONE_A;
    end else if (load_store_valid_i) begin
      load_store_ready_o = 1'b1;
      ram_addr_o         = load_store_addr_i;
      ram_we_o           = store_en_i;
      load_inflight_d    = ~store_en_i;
      pc_d               = next_pc;
    end else if (room) begin
      fetch_pc_d       = next_pc;
      fetch_inflight_d = 1'b1;
      pc_d             = next_pc + ONE_A;
    end else begin
      pc_d = next_pc;
    end
    // Nothing is granted or written while held in reset.
    if (!reset_n) begin
      ram_we_o           = 1'b0;
      load_store_ready_o = 1'b0;
    end
  end

  // FIFO occupancy tracking; a restart empties the FIFO.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enqueue && !deq_ok) begin
      cnt_d = cnt_q + ONE_C;
    end else if (!enqueue && deq_ok) begin
      cnt_d = cnt_q - ONE_C;
    end
  end

  // State registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q             <= '0;
      fetch_pc_q       <= '0;
      fetch_inflight_q <= 1'b0;
      load_inflight_q  <= 1'b0;
      cnt_q            <= '0;
    end else begin
      pc_q             <= pc_d;
      fetch_pc_q       <= fetch_pc_d;
      fetch_inflight_q <= fetch_inflight_d;
      load_inflight_q  <= load_inflight_d;
      cnt_q            <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios with a scoreboard. Stimulus pushes the
// expected packets/load data; a negedge monitor pops and compares them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        restart_i;
  logic [9:0]  restart_addr_i;
  logic        dequeue_i;
  logic        load_store_valid_i;
  logic        store_en_i;
  logic [9:0]  load_store_addr_i;
  logic [12:0] store_data_i;
  logic [12:0] ram_data_i;
  logic [9:0]  ram_addr_o;
  logic        ram_we_o;
  logic [12:0] ram_wdata_o;
  logic        load_store_ready_o;
  logic [12:0] load_data_o;
  logic        load_data_valid_o;
  logic        fifo_enqueue_o;
  logic        fifo_clear_o;
  logic [22:0] instr_packet_o;

  int vectors = 0;
  int errors  = 0;
  int enq_total  = 0;
  int load_total = 0;
  int occ = 0;

  logic [22:0] exp_pkt_q[$];
  logic [12:0] exp_load_q[$];
  logic [22:0] e_pkt;
  logic [12:0] e_load;

  logic [12:0] mem [1024];
  bit          init_done;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .restart_i          (restart_i),
    .restart_addr_i     (restart_addr_i),
    .dequeue_i          (dequeue_i),
    .load_store_valid_i (load_store_valid_i),
    .store_en_i         (store_en_i),
    .load_store_addr_i  (load_store_addr_i),
    .store_data_i       (store_data_i),
    .ram_data_i         (ram_data_i),
    .ram_addr_o         (ram_addr_o),
    .ram_we_o           (ram_we_o),
    .ram_wdata_o        (ram_wdata_o),
    .load_store_ready_o (load_store_ready_o),
    .load_data_o        (load_data_o),
    .load_data_valid_o  (load_data_valid_o),
    .fifo_enqueue_o     (fifo_enqueue_o),
    .fifo_clear_o       (fifo_clear_o),
    .instr_packet_o     (instr_packet_o)
  );

  // RAM image: address 5 is a branch with offset -3, 0x100 holds load data.
  function automatic logic [12:0] memval(int a);
    logic [31:0] v;
    if (a == 5)   return 13'h101D;
    if (a == 256) return 13'h0ABC;
    v = a * 5 + 3;
    return {1'b0, v[11:0]};
  endfunction

  function automatic logic [22:0] pkt(int a);
    logic [31:0] av;
    av = a;
    return {av[9:0], memval(a)};
  endfunction

  // Single-port RAM model with one-cycle registered read.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= memval(i);
      init_done <= 1'b1;
    end else if (ram_we_o) begin
      mem[ram_addr_o] <= ram_wdata_o;
    end
    ram_data_i <= mem[ram_addr_o];
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a packet or load data.
  always @(negedge clk) begin
    if (fifo_enqueue_o) begin
      enq_total++;
      $display("enq pc=%03h instr=%04h", instr_packet_o[22:13], instr_packet_o[12:0]);
      if (exp_pkt_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_enqueue: got %0h, expected none", instr_packet_o);
      end else begin
        e_pkt = exp_pkt_q.pop_front();
        check("packet", 32'(instr_packet_o), 32'(e_pkt));
      end
      check("enq_while_full", {31'b0, (occ == 8) && !dequeue_i}, 32'd0);
    end
    if (load_data_valid_o) begin
      load_total++;
      $display("load data=%04h", load_data_o);
      if (exp_load_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_load_valid: got %0h, expected none", load_data_o);
      end else begin
        e_load = exp_load_q.pop_front();
        check("load_data", 32'(load_data_o), 32'(e_load));
      end
    end
    if (fifo_clear_o) occ = 0;
    else occ = occ + (fifo_enqueue_o ? 1 : 0) - ((dequeue_i && occ > 0) ? 1 : 0);
  end

  // Directed stimulus, one cycle at a time.
  initial begin
    int s1_addr [8];
    s1_addr = '{0, 1, 2, 3, 4, 5, 2, 3};
    reset_n = 1'b0;
    restart_i = 1'b0;
    restart_addr_i = '0;
    dequeue_i = 1'b0;
    load_store_valid_i = 1'b1;
    store_en_i = 1'b1;
    load_store_addr_i = 10'h055;
    store_data_i = 13'h1555;

    // Reset: requests present but nothing granted or written.
    repeat (3) next();
    mid();
    check("rst_clear", {31'b0, fifo_clear_o}, 32'd1);
    check("rst_we", {31'b0, ram_we_o}, 32'd0);
    check("rst_ready", {31'b0, load_store_ready_o}, 32'd0);
    check("rst_enq", {31'b0, fifo_enqueue_o}, 32'd0);
    check("rst_lvalid", {31'b0, load_data_valid_o}, 32'd0);

    // Fill from 0; the branch at 5 loops back to 2; stop after 8 packets.
    for (int k = 0; k < 6; k++) exp_pkt_q.push_back(pkt(k));
    exp_pkt_q.push_back(pkt(2));
    exp_pkt_q.push_back(pkt(3));
    for (int k = 0; k < 12; k++) begin
      next();
      if (k == 0) begin
        reset_n = 1'b1;
        load_store_valid_i = 1'b0;
        store_en_i = 1'b0;
      end
      mid();
      if (k < 8) check("fill_addr", 32'(ram_addr_o), 32'(s1_addr[k]));
      if (k == 6) check("branch_pkt", 32'(instr_packet_o), {9'b0, 10'd5, 13'h101D});
    end
    check("full_no_enq", {31'b0, fifo_enqueue_o}, 32'd0);
    check("full_count", 32'(enq_total), 32'd8);

    // One dequeue frees one slot: exactly one more fetch at pc 4.
    next(); dequeue_i = 1'b1; mid();
    next(); dequeue_i = 1'b0; exp_pkt_q.push_back(pkt(4)); mid();
    check("resume_addr", 32'(ram_addr_o), 32'd4);
    next(); mid();
    check("resume_enq", {31'b0, fifo_enqueue_o}, 32'd1);
    next(); mid();
    check("refull_no_enq", {31'b0, fifo_enqueue_o}, 32'd0);

    // Restart at 3 and stream through the branch with continuous dequeue.
    next(); restart_i = 1'b1; restart_addr_i = 10'd3; exp_pkt_q.push_back(pkt(3)); mid();
    check("rs_clear", {31'b0, fifo_clear_o}, 32'd1);
    check("rs_addr", 32'(ram_addr_o), 32'd3);
    next(); restart_i = 1'b0; dequeue_i = 1'b1; exp_pkt_q.push_back(pkt(4)); mid();
    next(); exp_pkt_q.push_back(pkt(5)); mid();
    next(); mid();
    check("br_same_cycle_addr", 32'(ram_addr_o), 32'd2);
    check("br_enq", {31'b0, fifo_enqueue_o}, 32'd1);

    // Restart to 0x3F0 while the fetch at 2 returns: it is dropped.
    next(); restart_i = 1'b1; restart_addr_i = 10'h3F0; exp_pkt_q.push_back(pkt(10'h3F0)); mid();
    check("rs2_no_enq", {31'b0, fifo_enqueue_o}, 32'd0);
    check("rs2_clear", {31'b0, fifo_clear_o}, 32'd1);
    check("rs2_addr", 32'(ram_addr_o), 32'h3F0);
    for (int j = 1; j < 18; j++) begin
      next();
      if (j == 1) restart_i = 1'b0;
      if (j <= 16) exp_pkt_q.push_back(pkt((16'h3F0 + j) & 16'h3FF));
      mid();
      if (j == 15) check("wrap_3ff", 32'(ram_addr_o), 32'h3FF);
      if (j == 16) check("wrap_000", 32'(ram_addr_o), 32'h000);
    end

    // Load stalls fetch for one cycle; store writes without a valid pulse.
    next(); restart_i = 1'b1; restart_addr_i = 10'h010; exp_pkt_q.push_back(pkt(16)); mid();
    check("rs3_no_enq", {31'b0, fifo_enqueue_o}, 32'd0);
    next(); restart_i = 1'b0; exp_pkt_q.push_back(pkt(17)); mid();
    check("s1_addr", 32'(ram_addr_o), 32'h011);
    next(); load_store_valid_i = 1'b1; store_en_i = 1'b0; load_store_addr_i = 10'h100;
    exp_load_q.push_back(13'h0ABC); mid();
    check("ld_ready", {31'b0, load_store_ready_o}, 32'd1);
    check("ld_addr", 32'(ram_addr_o), 32'h100);
    check("ld_we", {31'b0, ram_we_o}, 32'd0);
    next(); load_store_valid_i = 1'b0; exp_pkt_q.push_back(pkt(18)); mid();
    check("ld_valid", {31'b0, load_data_valid_o}, 32'd1);
    check("ld_resume_addr", 32'(ram_addr_o), 32'h012);
    next(); load_store_valid_i = 1'b1; store_en_i = 1'b1; load_store_addr_i = 10'h101;
    store_data_i = 13'h1ABC; mid();
    check("st_we", {31'b0, ram_we_o}, 32'd1);
    check("st_wdata", 32'(ram_wdata_o), 32'h1ABC);
    check("st_addr", 32'(ram_addr_o), 32'h101);
    check("st_ready", {31'b0, load_store_ready_o}, 32'd1);
    next(); load_store_valid_i = 1'b0; store_en_i = 1'b0; exp_pkt_q.push_back(pkt(19)); mid();
    check("st_no_valid", {31'b0, load_data_valid_o}, 32'd0);
    check("st_ram", 32'(mem[10'h101]), 32'h1ABC);
    next(); mid();
    check("s6_enq", {31'b0, fifo_enqueue_o}, 32'd1);

    // Restart together with a store request: restart wins, no write.
    next(); restart_i = 1'b1; restart_addr_i = 10'h200; load_store_valid_i = 1'b1;
    store_en_i = 1'b1; load_store_addr_i = 10'h055; store_data_i = 13'h0777;
    exp_pkt_q.push_back(pkt(10'h200)); mid();
    check("rsls_ready", {31'b0, load_store_ready_o}, 32'd0);
    check("rsls_we", {31'b0, ram_we_o}, 32'd0);
    check("rsls_addr", 32'(ram_addr_o), 32'h200);
    next(); restart_i = 1'b0; load_store_valid_i = 1'b0; store_en_i = 1'b0;
    exp_pkt_q.push_back(pkt(10'h201)); mid();
    check("rsls_ram_kept", 32'(mem[10'h055]), 32'(memval(10'h055)));

    // Load, then reset the next cycle: no valid pulse, fetch restarts at 0.
    next(); load_store_valid_i = 1'b1; load_store_addr_i = 10'h100; mid();
    check("ld2_ready", {31'b0, load_store_ready_o}, 32'd1);
    next(); reset_n = 1'b0; load_store_valid_i = 1'b0; mid();
    check("rst2_lvalid", {31'b0, load_data_valid_o}, 32'd0);
    check("rst2_clear", {31'b0, fifo_clear_o}, 32'd1);
    next(); mid();
    next(); reset_n = 1'b1; exp_pkt_q.push_back(pkt(0)); mid();
    check("rst2_addr", 32'(ram_addr_o), 32'd0);
    next(); mid();
    check("rst2_enq", {31'b0, fifo_enqueue_o}, 32'd1);
    next(); reset_n = 1'b0; mid();
    next(); mid();

    check("pkt_queue_empty", 32'(exp_pkt_q.size()), 32'd0);
    check("load_queue_empty", 32'(exp_load_q.size()), 32'd0);
    check("enq_total", 32'(enq_total), 32'd36);
    check("load_total", 32'(load_total), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
